// File: rtl/pulse_train_generator_pkg.sv
// Shared IO-controller definitions for the pulse-train generator: default
// sizing and the sequencing state type.
package pulse_train_generator_pkg;

    localparam int MAX_WIDTH_DEF  = 1000000000;
    localparam int WIDTH_BITS_DEF = $clog2(MAX_WIDTH_DEF);
    localparam int MAX_PULSE_DEF  = 1024;
    localparam int PULSE_BITS_DEF = $clog2(MAX_PULSE_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_train_generator_if.sv
// Configuration, trigger and status bundle of the pulse-train generator.
// The master side programs and triggers; the slave side is the generator.
interface pulse_train_generator_if
    import pulse_train_generator_pkg::*;
#(
    parameter int WIDTH_BITS = WIDTH_BITS_DEF,
    parameter int PULSE_BITS = PULSE_BITS_DEF
);
    logic                  auto_start;
    logic [WIDTH_BITS-1:0] high_value;
    logic                  high_set;
    logic [WIDTH_BITS-1:0] low_value;
    logic                  low_set;
    logic [PULSE_BITS-1:0] count_value;
    logic                  count_set;
    logic                  polarity_value;
    logic                  polarity_set;
    logic                  trigger_in;
    logic                  output_signal;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    modport master (
        output auto_start, high_value, high_set, low_value, low_set,
               count_value, count_set, polarity_value, polarity_set, trigger_in,
        input  output_signal, busy, done, overrun
    );

    modport slave (
        input  auto_start, high_value, high_set, low_value, low_set,
               count_value, count_set, polarity_value, polarity_set, trigger_in,
        output output_signal, busy, done, overrun
    );

endinterface

// File: rtl/pulse_train_generator_phase_counter.sv
// Phase-length counter shared by the HIGH and LOW phases. Counts from 1 and
// flags terminal once the count reaches max(length,1); it then holds.
module pulse_train_generator_phase_counter
    import pulse_train_generator_pkg::*;
#(
    parameter int WIDTH_BITS = WIDTH_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  enable,
    input  logic [WIDTH_BITS-1:0] length,
    output logic                  terminal
);
    logic [WIDTH_BITS-1:0] width_cnt_q, width_cnt_d;
    logic [WIDTH_BITS-1:0] length_eff;

    always_comb begin
        length_eff  = (length == '0) ? WIDTH_BITS'(1) : length;
        terminal    = (width_cnt_q >= length_eff);
        width_cnt_d = width_cnt_q;
        if (load) begin
            width_cnt_d = WIDTH_BITS'(1);
        end else if (enable && !terminal) begin
            width_cnt_d = width_cnt_q + WIDTH_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_cnt_q <= '0;
        end else begin
            width_cnt_q <= width_cnt_d;
        end
    end

endmodule

// File: rtl/pulse_train_generator.sv
// Pulse-train generator: each accepted trigger emits N pulses of H active
// cycles separated by L inactive cycles on a polarity-selectable output.
//
// state | meaning
// IDLE  | waiting for a trigger; output sits at the idle level
// HIGH  | active phase of the current pulse
// LOW   | inactive gap between two pulses
module pulse_train_generator
    import pulse_train_generator_pkg::*;
#(
    parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
    parameter int WIDTH_BITS = $clog2(MAX_WIDTH),
    parameter int MAX_PULSE  = MAX_PULSE_DEF,
    parameter int PULSE_BITS = $clog2(MAX_PULSE) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pulse_train_generator_if.slave bus
);
    logic [WIDTH_BITS-1:0] high_q, high_d;
    logic [WIDTH_BITS-1:0] low_q, low_d;
    logic [PULSE_BITS-1:0] count_q, count_d;
    logic                  polarity_q, polarity_d;

    logic [WIDTH_BITS-1:0] high_sh_q, high_sh_d;
    logic [WIDTH_BITS-1:0] low_sh_q, low_sh_d;
    logic [PULSE_BITS-1:0] count_sh_q, count_sh_d;
    logic [PULSE_BITS-1:0] pulse_cnt_q, pulse_cnt_d;
    state_t                state_q, state_d;
    logic                  fin_q, fin_d;
    logic                  ovr_q, ovr_d;

    logic                  output_signal_q, output_signal_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    logic                  width_load;
    logic                  width_en;
    logic                  width_term;
    logic [WIDTH_BITS-1:0] width_len;

    always_comb begin
        high_d     = bus.high_set     ? bus.high_value     : high_q;
        low_d      = bus.low_set      ? bus.low_value      : low_q;
        count_d    = bus.count_set    ? bus.count_value    : count_q;
        polarity_d = bus.polarity_set ? bus.polarity_value : polarity_q;
    end

    // Train sequencing; the config registers are sampled as they were
    // before this edge, so a write coinciding with a trigger hits the next train.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        high_sh_d   = high_sh_q;
        low_sh_d    = low_sh_q;
        count_sh_d  = count_sh_q;
        width_load  = 1'b0;
        fin_d       = 1'b0;
        ovr_d       = 1'b0;

        if (!bus.auto_start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.trigger_in && (count_q != '0)) begin
                        high_sh_d   = high_q;
                        low_sh_d    = low_q;
                        count_sh_d  = count_q;
                        pulse_cnt_d = PULSE_BITS'(1);
                        width_load  = 1'b1;
                        state_d     = HIGH;
                    end
                end
                HIGH: begin
                    ovr_d = bus.trigger_in;
                    if (width_term) begin
                        if (pulse_cnt_q >= count_sh_q) begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end else begin
                            width_load = 1'b1;
                            state_d    = LOW;
                        end
                    end
                end
                LOW: begin
                    ovr_d = bus.trigger_in;
                    if (width_term) begin
                        width_load  = 1'b1;
                        pulse_cnt_d = pulse_cnt_q + PULSE_BITS'(1);
                        state_d     = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Visible outputs are a registered view of the sequencer state.
    always_comb begin
        width_en        = (state_q != IDLE);
        width_len       = (state_q == LOW) ? low_sh_q : high_sh_q;
        output_signal_d = (state_q == HIGH) ^ polarity_q;
        busy_d          = (state_q != IDLE);
        done_d          = fin_q;
        overrun_d       = ovr_q;
    end

    pulse_train_generator_phase_counter #(
        .WIDTH_BITS (WIDTH_BITS)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (width_load),
        .enable   (width_en),
        .length   (width_len),
        .terminal (width_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_q          <= '0;
            low_q           <= '0;
            count_q         <= '0;
            polarity_q      <= 1'b0;
            high_sh_q       <= '0;
            low_sh_q        <= '0;
            count_sh_q      <= '0;
            pulse_cnt_q     <= '0;
            state_q         <= IDLE;
            fin_q           <= 1'b0;
            ovr_q           <= 1'b0;
            output_signal_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            high_q          <= high_d;
            low_q           <= low_d;
            count_q         <= count_d;
            polarity_q      <= polarity_d;
            high_sh_q       <= high_sh_d;
            low_sh_q        <= low_sh_d;
            count_sh_q      <= count_sh_d;
            pulse_cnt_q     <= pulse_cnt_d;
            state_q         <= state_d;
            fin_q           <= fin_d;
            ovr_q           <= ovr_d;
            output_signal_q <= output_signal_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            overrun_q       <= overrun_d;
        end
    end

    assign bus.output_signal = output_signal_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed scenarios followed by random
// traffic, every cycle compared against a timeline-based train model.
module tb_pulse_train_generator;
    import pulse_train_generator_pkg::*;

    localparam int WB = WIDTH_BITS_DEF;
    localparam int PB = PULSE_BITS_DEF;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pulse_train_generator_if #(.WIDTH_BITS(WB), .PULSE_BITS(PB)) bus ();

    pulse_train_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Model: a train is a start edge plus its effective H/L/N; everything else
    // follows from where the current edge falls on that timeline.
    bit m_train;
    int m_s, m_h, m_l, m_n, m_t;
    int m_high, m_low, m_count;
    bit m_pol, m_fin, m_ovr;
    bit e_out, e_busy, e_done, e_ovr;

    int n_done, n_ovr, n_busy, n_one, n_zero, done_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_train = 0; m_s = 0; m_h = 1; m_l = 1; m_n = 0; m_t = 0;
        m_high = 0; m_low = 0; m_count = 0;
        m_pol = 0; m_fin = 0; m_ovr = 0;
        e_out = 0; e_busy = 0; e_done = 0; e_ovr = 0;
    endtask

    task automatic model_edge();
        int  age;
        bit  pre_act;
        bit  pre_high;
        edge_n++;
        if (!reset) begin
            model_reset();
            return;
        end
        age      = edge_n - m_s;
        pre_act  = m_train && (age >= 1) && (age <= m_t);
        pre_high = 0;
        if (pre_act) pre_high = ((age - 1) % (m_h + m_l)) < m_h;
        e_out  = pre_high ^ m_pol;
        e_busy = pre_act;
        e_done = m_fin;
        e_ovr  = m_ovr;
        m_fin  = bus.auto_start && pre_act && (age == m_t);
        m_ovr  = bus.auto_start && pre_act && bus.trigger_in;
        if (!bus.auto_start) begin
            m_train = 0;
        end else if (!pre_act && bus.trigger_in && (m_count != 0)) begin
            m_train = 1;
            m_s = edge_n;
            m_h = (m_high == 0) ? 1 : m_high;
            m_l = (m_low == 0) ? 1 : m_low;
            m_n = m_count;
            m_t = m_n * m_h + (m_n - 1) * m_l;
        end
        if (bus.high_set)     m_high  = int'(bus.high_value);
        if (bus.low_set)      m_low   = int'(bus.low_value);
        if (bus.count_set)    m_count = int'(bus.count_value);
        if (bus.polarity_set) m_pol   = bus.polarity_value;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("output_signal", bus.output_signal, e_out);
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("overrun", bus.overrun, e_ovr);
        if (bus.done) begin n_done++; done_edge = edge_n; end
        if (bus.overrun) n_ovr++;
        if (bus.busy) n_busy++;
        if (bus.output_signal) n_one++; else n_zero++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        n_done = 0; n_ovr = 0; n_busy = 0; n_one = 0; n_zero = 0; done_edge = -1;
    endtask

    task automatic cfg(input int h, input int l, input int n, input bit p);
        bus.high_value = WB'(h);   bus.high_set = 1;
        bus.low_value = WB'(l);    bus.low_set = 1;
        bus.count_value = PB'(n);  bus.count_set = 1;
        bus.polarity_value = p;    bus.polarity_set = 1;
        tick();
        bus.high_set = 0; bus.low_set = 0; bus.count_set = 0; bus.polarity_set = 0;
    endtask

    task automatic trig(output int s);
        bus.trigger_in = 1;
        tick();
        s = edge_n;
        bus.trigger_in = 0;
    endtask

    initial begin
        int s, s2;
        bus.auto_start = 0; bus.trigger_in = 0;
        bus.high_value = '0; bus.high_set = 0;
        bus.low_value = '0;  bus.low_set = 0;
        bus.count_value = '0; bus.count_set = 0;
        bus.polarity_value = 0; bus.polarity_set = 0;
        model_reset();
        clear_stats();

        ticks(3);
        reset = 1;
        ticks(2);
        chk("reset_out", bus.output_signal, 0);

        // H=3 L=2 N=3: 9 active cycles, done 14 edges after the trigger edge
        bus.auto_start = 1;
        cfg(3, 2, 3, 0);
        ticks(2);
        clear_stats();
        trig(s);
        ticks(16);
        chk("t1_active_cycles", n_one, 9);
        chk("t1_busy_cycles", n_busy, 13);
        chk("t1_done_latency", done_edge - s, 14);
        chk("t1_done_count", n_done, 1);

        // zero lengths clamp to one cycle
        cfg(0, 0, 2, 0);
        clear_stats();
        trig(s);
        ticks(6);
        chk("t2_active_cycles", n_one, 2);
        chk("t2_done_latency", done_edge - s, 4);

        // N=0: triggers ignored
        cfg(4, 4, 0, 0);
        clear_stats();
        for (int i = 0; i < 3; i++) begin trig(s); ticks(2); end
        chk("t3_busy_cycles", n_busy, 0);
        chk("t3_done_count", n_done, 0);
        chk("t3_overrun_count", n_ovr, 0);

        // overrun mid-train, then back-to-back retrigger on done
        cfg(5, 5, 4, 0);
        clear_stats();
        trig(s);
        ticks(6);
        bus.trigger_in = 1; tick(); bus.trigger_in = 0;
        for (int i = 0; i < 60 && !bus.done; i++) tick();
        chk("t4_done_seen", bus.done, 1);
        chk("t4_done_latency", done_edge - s, 36);
        chk("t4_overrun_count", n_ovr, 1);
        trig(s2);
        ticks(40);
        chk("t4_retrig_done_latency", done_edge - s2, 36);
        chk("t4_done_count", n_done, 2);
        chk("t4_active_cycles", n_one, 40);

        // active-low output; mid-train H write only affects the next train
        cfg(2, 3, 1, 1);
        ticks(2);
        chk("t5_idle_level", bus.output_signal, 1);
        clear_stats();
        trig(s);
        bus.high_value = WB'(10); bus.high_set = 1;
        tick();
        bus.high_set = 0;
        ticks(5);
        chk("t5_first_active", n_zero, 2);
        chk("t5_first_done", done_edge - s, 3);
        clear_stats();
        trig(s2);
        ticks(14);
        chk("t5_second_active", n_zero, 10);
        chk("t5_second_done", done_edge - s2, 11);

        // auto_start drop mid-HIGH aborts silently
        cfg(4, 2, 3, 0);
        clear_stats();
        trig(s);
        ticks(2);
        bus.auto_start = 0;
        ticks(3);
        trig(s);
        ticks(8);
        chk("t6_abort_busy", bus.busy, 0);
        chk("t6_abort_done", n_done, 0);
        chk("t6_abort_overrun", n_ovr, 0);
        chk("t6_abort_out", bus.output_signal, 0);
        bus.auto_start = 1;

        // async reset mid-train
        cfg(4, 2, 3, 1);
        trig(s);
        ticks(5);
        clear_stats();
        #3 reset = 0;
        #1;
        chk("t6_rst_out", bus.output_signal, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        chk("t6_rst_overrun", bus.overrun, 0);
        model_reset();
        ticks(2);
        reset = 1;
        ticks(20);
        chk("t6_rst_no_done", n_done, 0);
        chk("t6_rst_no_busy", n_busy, 0);

        // random traffic
        cfg(2, 1, 2, 0);
        for (int i = 0; i < 1500; i++) begin
            bus.trigger_in   = ($urandom_range(0, 7) == 0);
            bus.auto_start   = ($urandom_range(0, 59) != 0);
            bus.high_set     = ($urandom_range(0, 24) == 0);
            bus.high_value   = WB'($urandom_range(0, 6));
            bus.low_set      = ($urandom_range(0, 24) == 0);
            bus.low_value    = WB'($urandom_range(0, 5));
            bus.count_set    = ($urandom_range(0, 24) == 0);
            bus.count_value  = PB'($urandom_range(0, 4));
            bus.polarity_set = ($urandom_range(0, 49) == 0);
            bus.polarity_value = 1'($urandom_range(0, 1));
            tick();
        end
        bus.trigger_in = 0; bus.high_set = 0; bus.low_set = 0;
        bus.count_set = 0; bus.polarity_set = 0; bus.auto_start = 1;
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
